// File: rtl/bias_ctrl_if.sv
// Tile/output handshake bundle between the bias sequencer and the bias-add array datapath.
// master = bias_ctrl, slave = upstream accumulator / downstream consumer side.
interface bias_ctrl_if #(
  parameter int OC_BW = 4,
  parameter int B_BW  = 8
);
  logic             i_acc_valid;
  logic             o_acc_ready;
  logic             i_out_ready;
  logic             o_bias_en;
  logic [B_BW-1:0]  o_bias;
  logic             o_out_valid;
  logic [OC_BW-1:0] o_oc_idx;

  modport master (
    input  i_acc_valid, i_out_ready,
    output o_acc_ready, o_bias_en, o_bias, o_out_valid, o_oc_idx
  );

  modport slave (
    output i_acc_valid, i_out_ready,
    input  o_acc_ready, o_bias_en, o_bias, o_out_valid, o_oc_idx
  );
endinterface

// File: rtl/bias_ctrl.sv
// Bias-add array sequencer: per-channel bias table, tile gating with 1-deep skid on the
// array output register, channel/tile progress tracking and completion pulse.
module bias_ctrl #(
  parameter int NUM_OC_MAX = 16,
  parameter int OC_BW      = 4,
  parameter int B_BW       = 8,
  parameter int TILE_BW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [OC_BW:0]     i_num_oc,
  input  logic [TILE_BW-1:0] i_tiles_per_oc,
  input  logic               i_bias_wr,
  input  logic [OC_BW-1:0]   i_bias_waddr,
  input  logic [B_BW-1:0]    i_bias_wdata,
  bias_ctrl_if.master        bus,
  output logic               o_busy,
  output logic               o_done,
  output logic [1:0]         o_state
);

  // Handshakes: a tile moves when i_acc_valid && o_acc_ready (that cycle is o_bias_en);
  // an output moves when o_out_valid && i_out_ready. Valid is held until the transfer.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [OC_BW-1:0]   oc_idx_q, oc_idx_d;
  logic [TILE_BW-1:0] tile_cnt_q, tile_cnt_d;
  logic [OC_BW:0]     num_oc_q;
  logic [TILE_BW-1:0] tiles_q;
  logic               out_valid_q;
  logic [B_BW-1:0]    bias_tbl [NUM_OC_MAX];

  logic acc_ready;
  logic accept;
  logic last_tile;
  logic last_oc;

  assign last_tile = (tile_cnt_q == (tiles_q - TILE_BW'(1)));
  assign last_oc   = ({1'b0, oc_idx_q} == (num_oc_q - (OC_BW+1)'(1)));

  always_comb begin
    state_d    = state_q;
    oc_idx_d   = oc_idx_q;
    tile_cnt_d = tile_cnt_q;
    acc_ready  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          if ((i_num_oc == '0) || (i_tiles_per_oc == '0)) begin
            state_d = DONE;
          end else begin
            state_d    = RUN;
            oc_idx_d   = '0;
            tile_cnt_d = '0;
          end
        end
      end
      RUN: begin
        // The array output register is the only buffer: refill only as it empties.
        acc_ready = !out_valid_q || bus.i_out_ready;
        accept    = bus.i_acc_valid && acc_ready;
        if (accept) begin
          if (last_tile) begin
            tile_cnt_d = '0;
            if (last_oc) begin
              oc_idx_d = '0;
              state_d  = DRAIN;
            end else begin
              oc_idx_d = oc_idx_q + OC_BW'(1);
            end
          end else begin
            tile_cnt_d = tile_cnt_q + TILE_BW'(1);
          end
        end
      end
      DRAIN: begin
        if (!out_valid_q || bus.i_out_ready) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      oc_idx_q    <= '0;
      tile_cnt_q  <= '0;
      num_oc_q    <= '0;
      tiles_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      oc_idx_q   <= oc_idx_d;
      tile_cnt_q <= tile_cnt_d;
      if ((state_q == IDLE) && i_start) begin
        num_oc_q <= i_num_oc;
        tiles_q  <= i_tiles_per_oc;
      end
      if (accept) begin
        out_valid_q <= 1'b1;
      end else if (bus.i_out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Table is deliberately not reset so a mid-run reset keeps the loaded biases.
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && i_bias_wr) begin
      bias_tbl[i_bias_waddr] <= i_bias_wdata;
    end
  end

  assign bus.o_acc_ready = acc_ready;
  assign bus.o_bias_en   = accept;
  assign bus.o_bias      = bias_tbl[oc_idx_q];
  assign bus.o_out_valid = out_valid_q;
  assign bus.o_oc_idx    = oc_idx_q;
  assign o_busy          = (state_q == RUN) || (state_q == DRAIN);
  assign o_done          = (state_q == DONE);
  assign o_state         = state_q;

endmodule

// File: tb/tb_bias_ctrl.sv
// Randomized scoreboard bench for bias_ctrl: expected (channel, bias) per tile is queued at
// run start from a reference table; a negedge monitor pops on every accepted tile.
module tb_bias_ctrl;
  localparam int NUM_OC_MAX = 16;
  localparam int OC_BW      = 4;
  localparam int B_BW       = 8;
  localparam int TILE_BW    = 8;
  localparam int EW         = OC_BW + B_BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               i_start;
  logic [OC_BW:0]     i_num_oc;
  logic [TILE_BW-1:0] i_tiles_per_oc;
  logic               i_bias_wr;
  logic [OC_BW-1:0]   i_bias_waddr;
  logic [B_BW-1:0]    i_bias_wdata;
  logic               o_busy;
  logic               o_done;
  logic [1:0]         o_state;

  bias_ctrl_if #(.OC_BW(OC_BW), .B_BW(B_BW)) bus ();

  bias_ctrl #(
    .NUM_OC_MAX(NUM_OC_MAX), .OC_BW(OC_BW), .B_BW(B_BW), .TILE_BW(TILE_BW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_start(i_start), .i_num_oc(i_num_oc), .i_tiles_per_oc(i_tiles_per_oc),
    .i_bias_wr(i_bias_wr), .i_bias_waddr(i_bias_waddr), .i_bias_wdata(i_bias_wdata),
    .bus(bus.master),
    .o_busy(o_busy), .o_done(o_done), .o_state(o_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [B_BW-1:0] model_tbl [NUM_OC_MAX];
  logic [EW-1:0]   exp_q[$];
  int inflight = 0;
  int out_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid exactly while one accepted tile is not yet consumed.
  always @(negedge clk) begin
    if (rst) begin
      inflight = 0;
    end else begin
      check("out_valid", 32'(bus.o_out_valid), 32'(inflight != 0));
      check("bias_en_hs", 32'(bus.o_bias_en), 32'(bus.i_acc_valid && bus.o_acc_ready));
      if (bus.o_out_valid && !bus.i_out_ready) check("stall_ready", 32'(bus.o_acc_ready), 32'd0);
      if (!o_busy) check("idle_ready", 32'(bus.o_acc_ready), 32'd0);
      if (bus.o_bias_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_accept: got oc %0d bias 0x%0h expected no tile", bus.o_oc_idx, bus.o_bias);
        end else begin
          check("tile_oc_bias", 32'({bus.o_oc_idx, bus.o_bias}), 32'(exp_q.pop_front()));
        end
      end
      if (bus.o_out_valid && bus.i_out_ready) begin
        inflight--;
        out_cnt++;
      end
      if (bus.o_bias_en) inflight++;
      if (inflight > 1) check("skid_depth", 32'(inflight), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bias(input int addr, input logic [B_BW-1:0] data);
    i_bias_wr    = 1'b1;
    i_bias_waddr = OC_BW'(addr);
    i_bias_wdata = data;
    model_tbl[addr] = data;
    tick();
    i_bias_wr = 1'b0;
  endtask

  task automatic run(input int n_oc, input int n_t, input int v_pct, input int r_pct,
                     input bit poke, output int cyc);
    int total;
    int base;
    bit got;
    bit busy_seen;
    bit taken;
    bit last_busy;
    logic [OC_BW-1:0] last_oc;
    total = n_oc * n_t;
    for (int k = 0; k < total; k++) exp_q.push_back({OC_BW'(k / n_t), model_tbl[k / n_t]});
    base = out_cnt;
    i_num_oc = (OC_BW+1)'(n_oc);
    i_tiles_per_oc = TILE_BW'(n_t);
    i_start = 1'b1;
    bus.i_acc_valid = 1'b0;
    tick();
    i_start = 1'b0;
    cyc = 0;
    got = 0;
    busy_seen = 0;
    taken = 0;
    last_busy = 0;
    last_oc = '0;
    while (!got && cyc < 3000) begin
      if (!bus.i_acc_valid || taken) bus.i_acc_valid = ($urandom_range(0, 99) < v_pct);
      bus.i_out_ready = ($urandom_range(0, 99) < r_pct);
      i_start = 1'b0;
      i_bias_wr = 1'b0;
      if (poke && last_busy && ($urandom_range(0, 5) == 0)) begin
        i_start = 1'b1;
        i_bias_wr = 1'b1;
        i_bias_waddr = last_oc;
        i_bias_wdata = B_BW'($urandom);
      end
      @(negedge clk);
      taken = bus.o_bias_en;
      last_busy = o_busy;
      last_oc = bus.o_oc_idx;
      if (o_busy) busy_seen = 1;
      if (o_done) got = 1;
      else cyc++;
      tick();
    end
    bus.i_acc_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    i_start = 1'b0;
    i_bias_wr = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(o_done), 32'd0);
    check("idle_after_done", 32'(o_state), 32'd0);
    check("busy_after_done", 32'(o_busy), 32'd0);
    check("output_count", 32'(out_cnt - base), 32'(total));
    check("all_tiles_seen", 32'(exp_q.size()), 32'd0);
    check("busy_seen", 32'(busy_seen), 32'(total != 0));
    exp_q.delete();
    tick();
  endtask

  // ---------------- stimulus ----------------
  int cyc;

  initial begin
    rst = 1'b1;
    i_start = 1'b0;
    i_num_oc = '0;
    i_tiles_per_oc = '0;
    i_bias_wr = 1'b0;
    i_bias_waddr = '0;
    i_bias_wdata = '0;
    bus.i_acc_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
    check("rst_oc_idx", 32'(bus.o_oc_idx), 32'd0);
    tick();

    for (int i = 0; i < NUM_OC_MAX; i++) write_bias(i, B_BW'($urandom));
    write_bias(0, 8'd5);
    write_bias(1, 8'hFD);
    write_bias(2, 8'd127);

    // Full-rate run: 6 tiles back to back, done 7 cycles after the first accept cycle.
    run(3, 2, 100, 100, 0, cyc);
    check("full_rate_done_cycle", 32'(cyc), 32'd7);
    run(3, 2, 100, 40, 0, cyc);
    run(3, 2, 50, 100, 0, cyc);

    // Empty runs finish immediately.
    run(0, 2, 100, 100, 0, cyc);
    check("zero_oc_done_cycle", 32'(cyc), 32'd0);
    run(3, 0, 100, 100, 0, cyc);
    check("zero_tiles_done_cycle", 32'(cyc), 32'd0);

    // Writes and starts while busy must be ignored.
    run(4, 3, 80, 70, 1, cyc);

    // Reset with an output stalled in the array register.
    for (int k = 0; k < 12; k++) exp_q.push_back({OC_BW'(k / 4), model_tbl[k / 4]});
    i_num_oc = 5'd3;
    i_tiles_per_oc = 8'd4;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    bus.i_acc_valid = 1'b1;
    bus.i_out_ready = 1'b0;
    tick();
    @(negedge clk);
    check("pre_reset_valid", 32'(bus.o_out_valid), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_acc_valid = 1'b0;
    bus.i_out_ready = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_state", 32'(o_state), 32'd0);
    check("mid_rst_valid", 32'(bus.o_out_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_done", 32'(o_done), 32'd0);
      @(negedge clk);
    end
    tick();
    run(3, 2, 100, 100, 0, cyc);
    check("post_rst_done_cycle", 32'(cyc), 32'd7);

    // Randomized runs over the whole table.
    for (int r = 0; r < 8; r++) begin
      write_bias($urandom_range(0, NUM_OC_MAX - 1), B_BW'($urandom));
      run($urandom_range(1, NUM_OC_MAX), $urandom_range(1, 4),
          $urandom_range(30, 100), $urandom_range(30, 100), 1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
